// File: rtl/snes_pkg.sv
// Shared definitions for the SNES/NES controller front end.
//   - Button index constants: bit positions of each button in the
//     button vectors that run from the button board to the converter.
//   - N_SNES_BUTTONS: width of a full controller button vector.
//   - db_state_t: per-channel debouncer FSM state.
package snes_pkg;

  localparam int BTN_START      = 0;
  localparam int BTN_SEL        = 1;
  localparam int BTN_A          = 2;
  localparam int BTN_B          = 3;
  localparam int BTN_UP         = 4;
  localparam int BTN_DOWN       = 5;
  localparam int BTN_LEFT       = 6;
  localparam int BTN_RIGHT      = 7;

  localparam int N_SNES_BUTTONS = 8;

  typedef enum logic {
    STABLE   = 1'b0,
    COUNTING = 1'b1
  } db_state_t;

endpackage

// File: rtl/debounce_bit.sv
// Single-channel synchronizer + debouncer.
// There is no handshake on this block: the raw pin is sampled every clock
// and the outputs are plain registered levels and one-cycle pulses.
//
// Ports:
//   clk      - system clock
//   reset    - synchronous, active-high
//   raw      - asynchronous raw button pin
//   clean    - debounced level, 1 = pressed
//   pressed  - one-cycle pulse when clean goes 0 -> 1
//   released - one-cycle pulse when clean goes 1 -> 0
//   state    - current FSM state (STABLE / COUNTING), for observation
module debounce_bit
  import snes_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      raw,
  output logic      clean,
  output logic      pressed,
  output logic      released,
  output db_state_t state
);

  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

  logic                 s1;
  logic                 s2;
  logic                 lvl;
  db_state_t            state_q;
  db_state_t            state_d;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic [CNT_WIDTH-1:0] cnt_d;
  logic                 clean_q;
  logic                 clean_d;
  logic                 pressed_q;
  logic                 pressed_d;
  logic                 released_q;
  logic                 released_d;

  // Normalize polarity so lvl = 1 always means "pressed".
  assign lvl = s2 ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1         <= ACTIVE_LOW;
      s2         <= ACTIVE_LOW;
      state_q    <= STABLE;
      cnt_q      <= '0;
      clean_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      s1         <= raw;
      s2         <= s1;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      clean_q    <= clean_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    clean_d    = clean_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    unique case (state_q)
      STABLE: begin
        if (lvl != clean_q) begin
          state_d = COUNTING;
          cnt_d   = CNT_ONE;
        end else begin
          cnt_d   = '0;
        end
      end
      COUNTING: begin
        if (lvl == clean_q) begin
          // Bounce: abandon the count without touching the output.
          state_d = STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          // lvl held its new value for DEBOUNCE_CYCLES clocks: accept it.
          state_d    = STABLE;
          cnt_d      = '0;
          clean_d    = lvl;
          pressed_d  = lvl;
          released_d = ~lvl;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = STABLE;
        cnt_d   = '0;
      end
    endcase
  end

  assign clean    = clean_q;
  assign pressed  = pressed_q;
  assign released = released_q;
  assign state    = state_q;

endmodule

// File: rtl/button_debouncer.sv
// Multi-channel button synchronizer/debouncer feeding the NES
// parallel-to-serial converter. Each channel is an independent
// debounce_bit instance.
//
// Ports:
//   clk          - system clock (only clock)
//   reset        - synchronous, active-high
//   btn_raw      - asynchronous raw button pins
//   btn_clean    - debounced levels, 1 = pressed
//   btn_pressed  - one-cycle pulse per channel on clean 0 -> 1
//   btn_released - one-cycle pulse per channel on clean 1 -> 0
//   all_stable   - 1 when no channel is counting
module button_debouncer
  import snes_pkg::*;
#(
  parameter int N_BUTTONS       = N_SNES_BUTTONS,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_WIDTH       = 16,
  parameter bit ACTIVE_LOW      = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn_raw,
  output logic [N_BUTTONS-1:0] btn_clean,
  output logic [N_BUTTONS-1:0] btn_pressed,
  output logic [N_BUTTONS-1:0] btn_released,
  output logic                 all_stable
);

  // Per-channel FSM states, kept as a named array so they can be probed.
  db_state_t            ch_state [N_BUTTONS];
  logic [N_BUTTONS-1:0] counting;

  for (genvar i = 0; i < N_BUTTONS; i++) begin : g_ch
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .CNT_WIDTH       (CNT_WIDTH),
      .ACTIVE_LOW      (ACTIVE_LOW)
    ) u_bit (
      .clk      (clk),
      .reset    (reset),
      .raw      (btn_raw[i]),
      .clean    (btn_clean[i]),
      .pressed  (btn_pressed[i]),
      .released (btn_released[i]),
      .state    (ch_state[i])
    );
    assign counting[i] = (ch_state[i] == COUNTING);
  end

  // Derived only from state registers, so nothing combinational from btn_raw.
  assign all_stable = ~|counting;

endmodule
